// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer
// Mode FSM (RUN/PAUSE/ADJ_MIN/ADJ_SEC), owner of the minutes/seconds registers,
// switch synchronizers, pause-button debouncer and blink blanking.
// Optional feature macro: STOPWATCH_AUTOREPEAT_EN
//   When defined, a held increment request repeats on tick_2hz after one full
//   tick_2hz period of hold. When undefined, only rising edges increment.
//
// state   | meaning
// RUN     | time counts on tick_1hz
// PAUSE   | time frozen, paused=1
// ADJ_MIN | minutes adjustable, minute digits blink
// ADJ_SEC | seconds adjustable, second digits blink
module stopwatch_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ADJ,
  input  logic       SEL,
  input  logic       btn_pause,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       inc_min_req,
  input  logic       inc_sec_req,
  output logic [1:0] adj_state,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       paused,
  output logic       blank_min,
  output logic       blank_sec
);

  // Encoding chosen so paused and adj_state are direct state-register bits.
  typedef enum logic [2:0] {
    RUN     = 3'b000,
    PAUSE   = 3'b100,
    ADJ_MIN = 3'b001,
    ADJ_SEC = 3'b010
  } state_t;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_nxt;
  logic             saved_pause;
  logic             adj_s1, adj_s2, sel_s1, sel_s2, btn_s1, btn_s2;
  logic             btn_db, pause_evt;
  logic [CNT_W-1:0] db_cnt;
  logic             inc_min_d, inc_sec_d;
  logic             min_pulse, sec_pulse;
  logic             min_rep, sec_rep;

  // Two-flop synchronizers for the raw switches and the pause button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adj_s1 <= 1'b0;
      adj_s2 <= 1'b0;
      sel_s1 <= 1'b0;
      sel_s2 <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      adj_s1 <= ADJ;
      adj_s2 <= adj_s1;
      sel_s1 <= SEL;
      sel_s2 <= sel_s1;
      btn_s1 <= btn_pause;
      btn_s2 <= btn_s1;
    end
  end

  // Debouncer: down-counter reloads whenever the sample matches the accepted level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_db    <= 1'b0;
      db_cnt    <= '0;
      pause_evt <= 1'b0;
    end else begin
      pause_evt <= 1'b0;
      if (btn_s2 == btn_db) begin
        db_cnt <= DB_RELOAD;
      end else if (db_cnt == '0) begin
        btn_db    <= btn_s2;
        db_cnt    <= DB_RELOAD;
        pause_evt <= btn_s2;
      end else begin
        db_cnt <= db_cnt - 1'b1;
      end
    end
  end

`ifdef STOPWATCH_AUTOREPEAT_EN
  logic min_armed, sec_armed;

  // First tick_2hz of a hold only arms the repeat; later ones issue increments
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_armed <= 1'b0;
      sec_armed <= 1'b0;
    end else begin
      min_armed <= (inc_min_req & inc_min_d) ? (min_armed | tick_2hz) : 1'b0;
      sec_armed <= (inc_sec_req & inc_sec_d) ? (sec_armed | tick_2hz) : 1'b0;
    end
  end

  assign min_rep = inc_min_req & inc_min_d & min_armed & tick_2hz;
  assign sec_rep = inc_sec_req & inc_sec_d & sec_armed & tick_2hz;
`else
  assign min_rep = 1'b0;
  assign sec_rep = 1'b0;
`endif

  // Request edge detect; pulses are registered so updates land two cycles after the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_min_d <= 1'b0;
      inc_sec_d <= 1'b0;
      min_pulse <= 1'b0;
      sec_pulse <= 1'b0;
    end else begin
      inc_min_d <= inc_min_req;
      inc_sec_d <= inc_sec_req;
      min_pulse <= (inc_min_req & ~inc_min_d) | min_rep;
      sec_pulse <= (inc_sec_req & ~inc_sec_d) | sec_rep;
    end
  end

  // State register; remembers RUN vs PAUSE when an adjust state is entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      saved_pause <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == RUN || state == PAUSE) &&
          (state_nxt == ADJ_MIN || state_nxt == ADJ_SEC))
        saved_pause <= (state == PAUSE);
    end
  end

  // Next-state logic; ADJ has priority, pause events are dropped while adjusting
  always_comb begin
    state_nxt = state;
    if (adj_s2) begin
      state_nxt = sel_s2 ? ADJ_SEC : ADJ_MIN;
    end else begin
      case (state)
        RUN:              if (pause_evt) state_nxt = PAUSE;
        PAUSE:            if (pause_evt) state_nxt = RUN;
        ADJ_MIN, ADJ_SEC: state_nxt = saved_pause ? PAUSE : RUN;
        default:          state_nxt = RUN;
      endcase
    end
  end

  // Mode outputs are taken straight from state-register bits
  always_comb begin
    adj_state = state[1:0];
    paused    = state[2];
  end

  // Time registers: one update per cycle, chosen by the pre-transition state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      minutes <= 6'd0;
      seconds <= 6'd0;
    end else begin
      case (state)
        RUN: begin
          if (tick_1hz) begin
            if (seconds == 6'd59) begin
              seconds <= 6'd0;
              minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
            end else begin
              seconds <= seconds + 6'd1;
            end
          end
        end
        ADJ_MIN: if (min_pulse) minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        ADJ_SEC: if (sec_pulse) seconds <= (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
        default: ;
      endcase
    end
  end

  // Blink blanking for the adjusted digit group; cleared on any state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else if (state_nxt != state) begin
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      blank_min <= (state == ADJ_MIN) ? (blank_min ^ tick_2hz) : 1'b0;
      blank_sec <= (state == ADJ_SEC) ? (blank_sec ^ tick_2hz) : 1'b0;
    end
  end

endmodule
